// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-style control unit: state set,
// instruction field constants, ALU operation codes and mux select encodings.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    J_EX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: selects add/sub directly, or decodes the R-type
// funct field when the FSM requests it.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j).
// Write strobes are forced low while reset is held so an aborted instruction never commits.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] ALU_control,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c, illegal_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = FETCH;
    alu_op      = ALUOP_ADD;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_src      = PCSRC_ALU;

    case (state_q)
      FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPE_EX;
          OP_BEQ:       state_d = BEQ_EX;
          OP_ADDI:      state_d = ADDI_EX;
          OP_J:         state_d = J_EX;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        i_or_d  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
      end
      MEMWR: begin
        i_or_d      = 1'b1;
        mem_write_c = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = RTYPE_WB;
      end
      RTYPE_WB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
      end
      // Branch target was computed into ALUOut during DECODE; commit only on equality.
      BEQ_EX: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write_c = zero;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write_c = 1'b1;
      end
      J_EX: begin
        pc_write_c = 1'b1;
        pc_src     = PCSRC_JUMP;
      end
      default: state_d = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (ALU_control)
  );

  assign pc_write  = pc_write_c  & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign illegal   = illegal_c   & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: expected outputs come from an
// instruction-class / cycle-number table of the control behaviour.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic [3:0] ALU_control;
  logic       pc_write, ir_write, mem_write, reg_write, i_or_d;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [16:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum int {C_LW, C_SW, C_RT, C_BEQ, C_ADDI, C_J, C_ILL} cls_e;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .ALU_control (ALU_control),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .i_or_d      (i_or_d),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .illegal     (illegal)
  );

  // Strobes occupy the top five bits so reset checks can slice them out.
  assign obs = {pc_write, ir_write, mem_write, reg_write, illegal,
                i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, ALU_control};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %05h, expected %05h", tag, got, want);
    end
  endtask

  function automatic int cpi(input cls_e c);
    case (c)
      C_LW:    return 5;
      C_SW, C_RT, C_ADDI: return 4;
      C_BEQ, C_J: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [5:0] opcode_of(input cls_e c);
    logic [5:0] op;
    case (c)
      C_LW:   return 6'b100011;
      C_SW:   return 6'b101011;
      C_RT:   return 6'b000000;
      C_BEQ:  return 6'b000100;
      C_ADDI: return 6'b001000;
      C_J:    return 6'b000010;
      default: begin
        op = 6'($urandom);
        while (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010)
          op = 6'($urandom);
        return op;
      end
    endcase
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected output word for cycle cyc (1-based) of an instruction of class c.
  function automatic logic [16:0] expect_out(input cls_e c, input int cyc,
                                             input logic [5:0] f, input logic z);
    logic pcw, irw, mw, rw, ill, iod, rd, m2r, sa;
    logic [1:0] sb, ps;
    logic [3:0] alu;
    {pcw, irw, mw, rw, ill, iod, rd, m2r, sa} = '0;
    sb  = 2'b00;
    ps  = 2'b00;
    alu = 4'b0010;
    if (cyc == 1) begin
      pcw = 1'b1; irw = 1'b1; sb = 2'b01;
    end else if (cyc == 2) begin
      sb  = 2'b11;
      ill = (c == C_ILL);
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (cyc == 3) begin sa = 1'b1; sb = 2'b10; end
          else if (cyc == 4) begin iod = 1'b1; mw = (c == C_SW); end
          else begin rw = 1'b1; m2r = 1'b1; end
        end
        C_RT: begin
          if (cyc == 3) begin sa = 1'b1; alu = funct_alu(f); end
          else begin rw = 1'b1; rd = 1'b1; end
        end
        C_BEQ: begin
          sa = 1'b1; alu = 4'b0110; ps = 2'b01; pcw = z;
        end
        C_ADDI: begin
          if (cyc == 3) begin sa = 1'b1; sb = 2'b10; end
          else rw = 1'b1;
        end
        C_J: begin
          pcw = 1'b1; ps = 2'b10;
        end
        default: ;
      endcase
    end
    return {pcw, irw, mw, rw, ill, iod, rd, m2r, sa, sb, ps, alu};
  endfunction

  // Entered and left at 1 time unit after a rising edge. zmode 0/1 fixes zero, 2 randomizes.
  // rst_at > 0 asserts reset in that cycle and abandons the instruction.
  task automatic run_instr(input cls_e c, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int rst_at, input string name);
    logic z;
    for (int k = 1; k <= cpi(c); k++) begin
      z      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      opcode = (k == 1) ? 6'($urandom) : op;
      funct  = (k == 1) ? 6'($urandom) : fn;
      zero   = z;
      if (k == rst_at) begin
        reset = 1'b1;
        #2;
        check($sformatf("%s reset-strobes c%0d", name, k), 32'(obs[16:12]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      #2;
      check($sformatf("%s c%0d", name, k), 32'(obs), 32'(expect_out(c, k, fn, z)));
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [5:0] pick_funct();
    logic [5:0] tbl [5];
    tbl[0] = 6'b100000; tbl[1] = 6'b100010; tbl[2] = 6'b100100;
    tbl[3] = 6'b100101; tbl[4] = 6'b101010;
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 4)];
    return 6'($urandom);
  endfunction

  initial begin
    cls_e c;
    int   ra;
    reset  = 1'b1;
    opcode = 6'b000000;
    funct  = 6'b000000;
    zero   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset strobes", 32'(obs[16:12]), 32'd0);
    reset = 1'b0;

    run_instr(C_LW,   6'b100011, 6'b000000, 2, 0, "lw");
    run_instr(C_RT,   6'b000000, 6'b101010, 2, 0, "rtype slt");
    run_instr(C_BEQ,  6'b000100, 6'b000000, 1, 0, "beq zero=1");
    run_instr(C_BEQ,  6'b000100, 6'b000000, 0, 0, "beq zero=0");
    run_instr(C_ILL,  6'b111111, 6'b000000, 2, 0, "illegal 3f");
    run_instr(C_SW,   6'b101011, 6'b000000, 2, 0, "sw");
    run_instr(C_J,    6'b000010, 6'b000000, 2, 0, "j");
    run_instr(C_LW,   6'b100011, 6'b000000, 2, 4, "lw abort");
    run_instr(C_ADDI, 6'b001000, 6'b000000, 2, 0, "addi after abort");

    for (int i = 0; i < 400; i++) begin
      c  = cls_e'($urandom_range(0, 6));
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, cpi(c))) : 0;
      run_instr(c, opcode_of(c), pick_funct(), 2, ra, $sformatf("rand%0d cls%0d", i, c));
    end

    opcode = 6'($urandom);
    funct  = 6'($urandom);
    #2;
    check("final fetch", 32'(obs), 32'(expect_out(C_J, 1, 6'b000000, 1'b0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction[31:26], taken from the instruction register.
REQ-004 SHALL have port funct, input, 6 bits: instruction[5:0], taken from the instruction register.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag for the current cycle.
REQ-006 SHALL have port ALU_control, output, 4 bits: ALU operation code (AND 0000, OR 0001, add 0010, sub 0110, slt 0111).
REQ-007 SHALL have ports pc_write, ir_write, mem_write, reg_write, i_or_d, reg_dst, mem_to_reg and alu_src_a, all outputs, 1 bit each: datapath strobes and mux selects.
REQ-008 SHALL have port alu_src_b, output, 2 bits: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-009 SHALL have port pc_src, output, 2 bits: 00 = ALU result, 01 = ALU output register, 10 = jump target.
REQ-010 SHALL have port illegal, output, 1 bit: one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB and J_EX.
REQ-012 FETCH SHALL assert ir_write=1 and pc_write=1, with alu_src_a=0, alu_src_b=01, ALU_control=0010, pc_src=00 and i_or_d=0, and SHALL go to DECODE.
REQ-013 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and ALU_control=0010, and SHALL go to the next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> RTYPE_EX
- 000100 (beq) -> BEQ_EX
- 001000 (addi) -> ADDI_EX
- 000010 (j) -> J_EX
- any other opcode -> FETCH, with illegal=1 for that cycle
REQ-014 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and ALU_control=0010, and SHALL go to MEMRD for lw or MEMWR for sw.
REQ-015 MEMRD SHALL drive i_or_d=1 and go to MEMWB; MEMWB SHALL assert reg_write=1 with reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-016 MEMWR SHALL assert i_or_d=1 and mem_write=1, then go to FETCH.
REQ-017 RTYPE_EX SHALL drive alu_src_a=1, alu_src_b=00 and ALU_control decoded from funct:
- 100000 -> 0010
- 100010 -> 0110
- 100100 -> 0000
- 100101 -> 0001
- 101010 -> 0111
- any other funct -> 0010
It SHALL then go to RTYPE_WB.
REQ-018 RTYPE_WB SHALL assert reg_write=1 with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-019 BEQ_EX SHALL drive alu_src_a=1, alu_src_b=00, ALU_control=0110 and pc_src=01, SHALL set pc_write=zero in the same cycle, and SHALL then go to FETCH.
REQ-020 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10 and ALU_control=0010, then go to ADDI_WB; ADDI_WB SHALL assert reg_write=1 with reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-021 J_EX SHALL assert pc_write=1 with pc_src=10, then go to FETCH.
REQ-022 In any state, any output not listed for that state SHALL be 0, with ALU_control defaulting to 0010.
REQ-023 Cycles per instruction SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-024 opcode and funct SHALL be sampled only in DECODE and later states; their values during FETCH SHALL NOT affect state.

Reset
REQ-025 reset=1 at a clock edge SHALL force the state to FETCH regardless of the current state, including mid-instruction.
REQ-026 While reset=1, all strobes (pc_write, ir_write, mem_write, reg_write, illegal) SHALL be 0.
REQ-027 The first FETCH strobes SHALL appear in the first cycle after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the opcode constants, the funct constants, the ALU_control codes and the alu_src_b and pc_src encodings.
REQ-029 The funct-to-ALU_control mapping SHALL be a combinational sub-module named alu_decoder, taking a 2-bit alu_op input (00 add, 01 sub, 10 funct) and funct.

Verification
REQ-030 Scenario: reset, then lw opcode 100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 in cycle 5 only; mem_to_reg=1.
REQ-031 Scenario: R-type with funct 101010 -> ALU_control=0111 in cycle 3; reg_write=1 with reg_dst=1 in cycle 4.
REQ-032 Scenario: beq with zero=1 -> pc_write=1 and pc_src=01 in cycle 3; repeated with zero=0 -> pc_write=0; both return to FETCH.
REQ-033 Scenario: opcode 111111 -> illegal=1 in DECODE; FETCH next cycle; no mem_write or reg_write.
REQ-034 Scenario: sw, then j -> mem_write=1 exactly once in cycle 4; j asserts pc_write with pc_src=10 in cycle 3.
REQ-035 Scenario: reset asserted during MEMRD -> FETCH on the next cycle; reg_write never asserts for the aborted lw.
